// File: rtl/ub_pkg.sv
// Shared types and helpers for the unified buffer stream block.
package ub_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } ub_state_e;

    localparam int UB_FIFO_DEPTH = 2;
    localparam int UB_CNT_W      = $clog2(UB_FIFO_DEPTH + 1);

    // One byte lane of a masked merge; the write path and forwarding both use it.
    function automatic logic [7:0] ub_lane_merge(
        input logic [7:0] old_byte,
        input logic [7:0] new_byte,
        input logic       lane_en
    );
        logic [7:0] res;
        if (lane_en) begin
            res = new_byte;
        end else begin
            res = old_byte;
        end
        return res;
    endfunction

endpackage

// File: rtl/ub_skid_fifo.sv
// Two-entry output FIFO between the SRAM read register and the stream port.
// The head entry drives dout directly, so data holds steady while the consumer stalls.
module ub_skid_fifo
    import ub_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                push,
    input  logic                pop,
    input  logic [WIDTH-1:0]    din,
    output logic [WIDTH-1:0]    dout,
    output logic                valid,
    output logic [UB_CNT_W-1:0] count
);

    logic [WIDTH-1:0]    head_q, head_d;
    logic [WIDTH-1:0]    tail_q, tail_d;
    logic [UB_CNT_W-1:0] cnt_q, cnt_d;
    logic                valid_q, valid_d;
    logic                push_s, pop_s, full_s;

    // Qualify the handshakes against the current occupancy
    always_comb begin
        full_s = (cnt_q == UB_CNT_W'(UB_FIFO_DEPTH));
        pop_s  = pop && valid_q;
        push_s = push && (!full_s || pop_s);
    end

    // Next-state for the two entries and the occupancy count
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        case ({push_s, pop_s})
            2'b10: begin
                if (cnt_q == UB_CNT_W'(0)) begin
                    head_d = din;
                end else begin
                    tail_d = din;
                end
                cnt_d = cnt_q + UB_CNT_W'(1);
            end
            2'b01: begin
                head_d = tail_q;
                cnt_d  = cnt_q - UB_CNT_W'(1);
            end
            2'b11: begin
                // Simultaneous push/pop keeps the count; a full FIFO shifts.
                if (full_s) begin
                    head_d = tail_q;
                    tail_d = din;
                end else begin
                    head_d = din;
                end
            end
            default: begin
                cnt_d = cnt_q;
            end
        endcase
        valid_d = (cnt_d != UB_CNT_W'(0));
    end

    // FIFO state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
        end
    end

    assign dout  = head_q;
    assign valid = valid_q;
    assign count = cnt_q;

endmodule

// File: rtl/unified_buffer_stream.sv
// Byte-masked write port plus a credit-limited burst-read engine streaming over valid/ready.
// Optional macro UB_RW_FORWARD_EN forwards a same-cycle write into a colliding read.
module unified_buffer_stream
    import ub_pkg::*;
#(
    parameter  int ADDRESSSIZE = 10,
    parameter  int WORDSIZE    = 64,
    parameter  int LENSIZE     = 8,
    localparam int LANES       = WORDSIZE / 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [ADDRESSSIZE-1:0] wr_addr,
    input  logic [LANES-1:0]       wr_mask,
    input  logic [WORDSIZE-1:0]    wr_data,
    input  logic                   rd_start,
    input  logic [ADDRESSSIZE-1:0] rd_base,
    input  logic [LENSIZE-1:0]     rd_len,
    output logic [WORDSIZE-1:0]    rd_data,
    output logic                   rd_valid,
    input  logic                   rd_ready,
    output logic                   busy,
    output logic                   rd_done
);

    localparam int DEPTH = 1 << ADDRESSSIZE;

    logic [WORDSIZE-1:0]    mem_q [DEPTH];

    ub_state_e              state_q, state_d;
    logic [ADDRESSSIZE-1:0] addr_q, addr_d;
    logic [LENSIZE-1:0]     left_q, left_d;
    logic                   inflight_q, inflight_d;
    logic [WORDSIZE-1:0]    sram_rdata_q, sram_rdata_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    logic [WORDSIZE-1:0]    wr_merged_s;
    logic [WORDSIZE-1:0]    rd_word_s;
    logic                   issue_s, pop_s, rd_valid_s;
    logic [2:0]             used_s;
    logic [UB_CNT_W-1:0]    fifo_cnt_s;

    // Merge the write data into the addressed word lane by lane
    always_comb begin
        wr_merged_s = mem_q[wr_addr];
        for (int k = 0; k < LANES; k++) begin
            wr_merged_s[8*k +: 8] = ub_lane_merge(mem_q[wr_addr][8*k +: 8],
                                                  wr_data[8*k +: 8], wr_mask[k]);
        end
    end

    // SRAM array write port; contents survive reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_merged_s;
        end
    end

    // Word returned by a read issued this cycle
    always_comb begin
`ifdef UB_RW_FORWARD_EN
        if (wr_en && (wr_addr == addr_q)) begin
            rd_word_s = wr_merged_s;
        end else begin
            rd_word_s = mem_q[addr_q];
        end
`else
        rd_word_s = mem_q[addr_q];
`endif
    end

    // Credit check: a word popped this cycle frees its slot for a new issue
    always_comb begin
        pop_s  = rd_valid_s && rd_ready;
        used_s = 3'(fifo_cnt_s) + 3'(inflight_q) - 3'(pop_s);
        if ((state_q == RUN) && (left_q != LENSIZE'(0)) && (used_s < 3'd2)) begin
            issue_s = 1'b1;
        end else begin
            issue_s = 1'b0;
        end
    end

    // Burst FSM next-state and read-pointer update
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        left_d  = left_q;
        case (state_q)
            IDLE: begin
                if (rd_start) begin
                    addr_d = rd_base;
                    left_d = rd_len;
                    if (rd_len == LENSIZE'(0)) begin
                        state_d = DONE;
                    end else begin
                        state_d = RUN;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (issue_s) begin
                    addr_d = addr_q + ADDRESSSIZE'(1);
                    left_d = left_q - LENSIZE'(1);
                    if (left_q == LENSIZE'(1)) begin
                        state_d = DRAIN;
                    end else begin
                        state_d = RUN;
                    end
                end else begin
                    state_d = RUN;
                end
            end
            DRAIN: begin
                if (!inflight_q && ((fifo_cnt_s == UB_CNT_W'(0)) ||
                                    ((fifo_cnt_s == UB_CNT_W'(1)) && pop_s))) begin
                    state_d = DONE;
                end else begin
                    state_d = DRAIN;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // SRAM read register and status outputs; rd_done trails the DONE state by one cycle
    always_comb begin
        inflight_d = issue_s;
        if (issue_s) begin
            sram_rdata_d = rd_word_s;
        end else begin
            sram_rdata_d = sram_rdata_q;
        end
        busy_d = (state_d != IDLE);
        done_d = (state_q == DONE);
    end

    // Engine state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            left_q       <= '0;
            inflight_q   <= 1'b0;
            sram_rdata_q <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            left_q       <= left_d;
            inflight_q   <= inflight_d;
            sram_rdata_q <= sram_rdata_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    ub_skid_fifo #(
        .WIDTH (WORDSIZE)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (inflight_q),
        .pop   (pop_s),
        .din   (sram_rdata_q),
        .dout  (rd_data),
        .valid (rd_valid_s),
        .count (fifo_cnt_s)
    );

    assign rd_valid = rd_valid_s;
    assign busy     = busy_q;
    assign rd_done  = done_q;

endmodule

// File: tb/tb_unified_buffer_stream.sv
// Directed bench for unified_buffer_stream: queue-based word model plus cycle-level checks.
`timescale 1ns/1ps
module tb_unified_buffer_stream;

    localparam int INF = 32'h7fffffff;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic [9:0]  wr_addr = 10'd0;
    logic [7:0]  wr_mask = 8'd0;
    logic [63:0] wr_data = 64'd0;
    logic        rd_start = 1'b0;
    logic [9:0]  rd_base = 10'd0;
    logic [7:0]  rd_len = 8'd0;
    logic [63:0] rd_data;
    logic        rd_valid;
    logic        rd_ready = 1'b1;
    logic        busy;
    logic        rd_done;

    always #5 clk = ~clk;

    unified_buffer_stream dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_mask  (wr_mask),
        .wr_data  (wr_data),
        .rd_start (rd_start),
        .rd_base  (rd_base),
        .rd_len   (rd_len),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .rd_ready (rd_ready),
        .busy     (busy),
        .rd_done  (rd_done)
    );

    logic [63:0] mem_m [1024];
    logic [63:0] exp_q [$];
    logic [63:0] rx_q [$];
    int          n_tests = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          acc_cyc = 0;
    int          done_at = INF;
    int          first_valid_cyc = -1;
    int          last_xfer_cyc = -1;
    int          done_cyc = -1;
    bit          active = 1'b0;
    bit          done_flag = 1'b0;
    bit          stall_prev = 1'b0;
    bit          rand_mode = 1'b0;
    bit          exp_busy;
    logic [63:0] prev_data = 64'd0;
    logic [63:0] w0, w1, w2, w3, coll_exp;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", nm, act, req);
        end
    endtask

    // Compare process: model of the stream, sampled on the falling edge
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                chk("rst_valid", 64'(rd_valid), 64'd0);
                chk("rst_busy", 64'(busy), 64'd0);
                chk("rst_done", 64'(rd_done), 64'd0);
                chk("rst_data", rd_data, 64'd0);
                exp_q.delete();
                active = 1'b0;
                stall_prev = 1'b0;
                done_at = INF;
            end else begin
                exp_busy = active && (cyc > acc_cyc) && (cyc < done_at);
                chk("busy", 64'(busy), 64'(exp_busy));
                chk("rd_done", 64'(rd_done), 64'(cyc == done_at));
                if (rd_done) begin
                    done_flag = 1'b1;
                    done_cyc = cyc;
                end
                if (active && cyc >= done_at) active = 1'b0;
                if (rd_start && !exp_busy) begin
                    acc_cyc = cyc;
                    active = 1'b1;
                    first_valid_cyc = -1;
                    last_xfer_cyc = -1;
                    done_at = INF;
                    for (int i = 0; i < int'(rd_len); i++)
                        exp_q.push_back(mem_m[(int'(rd_base) + i) % 1024]);
                    if (rd_len == 8'd0) done_at = cyc + 2;
                end
                if (stall_prev) begin
                    chk("valid_held", 64'(rd_valid), 64'd1);
                    chk("stall_data", rd_data, prev_data);
                end
                if (rd_valid) begin
                    if (first_valid_cyc < 0) first_valid_cyc = cyc;
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL spurious_valid: got rd_valid=1 data %h, required rd_valid=0", rd_data);
                    end else begin
                        chk("rd_data", rd_data, exp_q[0]);
                        if (rd_ready) begin
                            rx_q.push_back(rd_data);
                            void'(exp_q.pop_front());
                            if (exp_q.size() == 0) begin
                                last_xfer_cyc = cyc;
                                done_at = cyc + 2;
                            end
                        end
                    end
                end
                stall_prev = rd_valid && !rd_ready;
                prev_data = rd_data;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_start = 1'b0;
        if (rand_mode) rd_ready = 1'($urandom_range(0, 1));
        else rd_ready = 1'b1;
    endtask

    task automatic wr(input int a, input logic [63:0] d, input logic [7:0] m);
        step();
        wr_en = 1'b1;
        wr_addr = 10'(a);
        wr_data = d;
        wr_mask = m;
        for (int k = 0; k < 8; k++)
            if (m[k]) mem_m[a][8*k +: 8] = d[8*k +: 8];
    endtask

    task automatic start(input int base, input int len);
        step();
        rd_start = 1'b1;
        rd_base = 10'(base);
        rd_len = 8'(len);
        rx_q.delete();
        done_flag = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int len);
        int t = 0;
        while (!done_flag && t < 400) begin
            step();
            t++;
        end
        if (!done_flag) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_timeout: got no rd_done in 400 cycles, required a pulse", nm);
        end
        chk({nm, "_count"}, 64'(rx_q.size()), 64'(len));
        step();
    endtask

    function automatic logic [63:0] rx_at(input int i);
        if (i < rx_q.size()) return rx_q[i];
        else return 64'hDEAD_DEAD_DEAD_DEAD;
    endfunction

    initial begin
        int t;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("init_busy", 64'(busy), 64'd0);
        chk("init_valid", 64'(rd_valid), 64'd0);

        for (int a = 0; a < 16; a++) wr(a, 64'(a), 8'hFF);
        wr(1022, 64'h0000_03FE_0000_CAFE, 8'hFF);
        wr(1023, 64'h0000_03FF_0000_CAFE, 8'hFF);

        // Streaming with a start command issued mid-burst that must be ignored
        start(0, 16);
        repeat (4) step();
        rd_start = 1'b1;
        rd_base = 10'd100;
        rd_len = 8'd3;
        wait_done("stream", 16);
        chk("stream_first_valid", 64'(first_valid_cyc - acc_cyc), 64'd3);
        chk("stream_last_xfer", 64'(last_xfer_cyc - acc_cyc), 64'd18);
        chk("stream_done", 64'(done_cyc - acc_cyc), 64'd20);
        chk("stream_w0", rx_at(0), 64'd0);
        chk("stream_w15", rx_at(15), 64'd15);

        // Masked write and a no-op all-lanes-off write
        wr(5, 64'h1111_1111_1111_1111, 8'hFF);
        wr(5, 64'hAAAA_AAAA_AAAA_AAAA, 8'h0F);
        wr(6, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00);
        start(5, 2);
        wait_done("mask", 2);
        chk("mask_word", rx_at(0), 64'h1111_1111_AAAA_AAAA);
        chk("mask_noop", rx_at(1), 64'd6);

        // Wrap-around burst under random backpressure
        rand_mode = 1'b1;
        start(1022, 4);
        wait_done("wrap", 4);
        rand_mode = 1'b0;
        w0 = rx_at(0); w1 = rx_at(1); w2 = rx_at(2); w3 = rx_at(3);
        chk("wrap_w0", w0, 64'h0000_03FE_0000_CAFE);
        chk("wrap_w1", w1, 64'h0000_03FF_0000_CAFE);
        chk("wrap_w2", w2, 64'd0);
        chk("wrap_w3", w3, 64'd1);

        // Zero-length burst
        start(3, 0);
        wait_done("len0", 0);
        chk("len0_done", 64'(done_cyc - acc_cyc), 64'd2);
        chk("len0_novalid", 64'(first_valid_cyc), 64'hFFFF_FFFF_FFFF_FFFF);

        // Same-cycle write/read collision on address 7
        wr(7, 64'h0707_0707_0707_0707, 8'hFF);
        start(7, 1);
        wr(7, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
`ifdef UB_RW_FORWARD_EN
        coll_exp = 64'hFFFF_FFFF_FFFF_FFFF;
        if (exp_q.size() > 0) exp_q[0] = coll_exp;
`else
        coll_exp = 64'h0707_0707_0707_0707;
`endif
        wait_done("coll", 1);
        chk("coll_word", rx_at(0), coll_exp);

        // Reset in the middle of a burst
        start(0, 8);
        t = 0;
        while (rx_q.size() < 3 && t < 100) begin
            step();
            t++;
        end
        chk("rst_mid_progress", 64'(rx_q.size()), 64'd3);
        rst = 1'b1;
        #1;
        chk("rst_now_valid", 64'(rd_valid), 64'd0);
        chk("rst_now_busy", 64'(busy), 64'd0);
        chk("rst_now_done", 64'(rd_done), 64'd0);
        step();
        step();
        rst = 1'b0;
        step();
        start(0, 2);
        wait_done("post_rst", 2);
        chk("post_rst_w0", rx_at(0), 64'd0);
        chk("post_rst_w1", rx_at(1), 64'd1);
        start(5, 1);
        wait_done("intact", 1);
        chk("intact_w5", rx_at(0), 64'h1111_1111_AAAA_AAAA);

        repeat (2) step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
